seg_scan_driver: RTL and testbench

//  Parametrised successor to the single-digit hex-to-7-segment decoder.
//  - Time-multiplexes DIGITS hex nibbles onto one shared segment bus with per-digit anode enables.
//  - Loads new values through a double buffer, so updates land only at frame boundaries and never tear.
//  - Provides PWM brightness control and global blanking.
//  - Sits between the system datapath and the board's multi-digit display pins.

---
 rtl/seg_scan_driver.sv | 94 +++++++++
 tb/tb_seg_scan_driver.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed DIGITS-wide hex display driver with double-buffered loads, PWM and blanking.
// Define SEG_LZB_EN to enable leading-zero blanking of digits above the most significant nonzero nibble.
module seg_scan_driver #(
   parameter int DIGITS         = 4,
   parameter int CLK_DIV        = 1000,
   parameter bit SEG_ACTIVE_LOW = 1,
   parameter bit AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_in,
   input  logic [3:0]            brightness,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  pending,
   output logic                  frame_tick
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [DW-1:0]         div_cnt;
   logic [IW-1:0]         idx;
   logic [3:0]            pwm_cnt;
   logic [4*DIGITS-1:0]   act_val, pend_val;
   logic [DIGITS-1:0]     act_dp, pend_dp;
   logic [3:0]            cur_nib;
   logic                  cur_dp, show, div_wrap, boundary, en;
`ifdef SEG_LZB_EN
   logic [IW-1:0]         msd;
`endif
   always_comb begin
      cur_nib = '0;
      cur_dp = 1'b0;
`ifdef SEG_LZB_EN
      msd = '0;
`endif
      for (int i = 0; i < DIGITS; i++) begin
         if (IW'(i) == idx) begin
            cur_nib = act_val[4*i +: 4];
            cur_dp = act_dp[i];
         end
`ifdef SEG_LZB_EN
         if (act_val[4*i +: 4] != 4'h0) msd = IW'(i);
`endif
      end
`ifdef SEG_LZB_EN
      show = idx <= msd;
`else
      show = 1'b1;
`endif
   end
   assign div_wrap = div_cnt == DW'(CLK_DIV - 1);
   assign boundary = div_wrap && idx == IW'(DIGITS - 1);
   // The div_cnt==0 cycle of each slot is the ghost gap that hides anode switching.
   assign en = div_cnt != '0 && pwm_cnt <= brightness && !blank_in && show;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt <= '0;
         idx <= '0;
         pwm_cnt <= '0;
         act_val <= '0;
         act_dp <= '0;
         pend_val <= '0;
         pend_dp <= '0;
         pending <= 1'b0;
         frame_tick <= 1'b0;
         seg <= {7{SEG_ACTIVE_LOW}};
         dp <= SEG_ACTIVE_LOW;
         an <= {DIGITS{AN_ACTIVE_LOW}};
      end else begin
         div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
         if (div_wrap) idx <= boundary ? '0 : idx + 1'b1;
         pwm_cnt <= pwm_cnt + 4'd1;
         frame_tick <= boundary;
         if (boundary && pending) begin
            act_val <= pend_val;
            act_dp <= pend_dp;
         end
         if (load) begin
            pend_val <= value;
            pend_dp <= dp_in;
         end
         pending <= load ? 1'b1 : boundary ? 1'b0 : pending;
         seg <= TBL[cur_nib] ^ {7{SEG_ACTIVE_LOW}};
         dp <= (cur_dp & show) ^ SEG_ACTIVE_LOW;
         an <= (en ? DIGITS'(1) << idx : '0) ^ {DIGITS{AN_ACTIVE_LOW}};
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed table checks plus randomized run against a cycle-count based reference model.
module tb_seg_scan_driver;
   logic        clk = 0, rst_n = 0, load = 0, blank_in = 0;
   logic [15:0] value = 0;
   logic [3:0]  dp_in = 0, brightness = 15;
   logic [6:0]  seg;
   logic        dp, pending, frame_tick;
   logic [3:0]  an;
   int checks = 0, errors = 0;
   int t = 0;
   logic [15:0] m_act = 0, m_pbuf = 0;
   logic [3:0]  m_adp = 0, m_pdp = 0;
   bit          m_pend = 0;
   localparam logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   typedef struct { logic [15:0] v; logic [6:0] s; } vec_t;
   vec_t vec [16];

   seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in), .blank_in(blank_in),
      .brightness(brightness), .seg(seg), .dp(dp), .an(an), .pending(pending), .frame_tick(frame_tick));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Outputs seen after an edge reflect the model state just before it.
   task automatic step();
      logic [6:0] e_seg;
      logic       e_dp, e_ft;
      logic [3:0] e_an, nb;
      int idx, dv, pw, msd;
      bit show;
      if (!rst_n) begin
         e_seg = 7'h7F; e_dp = 1; e_an = 4'hF; e_ft = 0;
      end else begin
         idx = (t / 4) % 4; dv = t % 4; pw = t % 16; msd = 0;
         for (int k = 0; k < 4; k++) if (m_act[4*k +: 4] != 0) msd = k;
         show = 1;
`ifdef SEG_LZB_EN
         show = idx <= msd;
`endif
         nb = m_act[4*idx +: 4];
         e_seg = ~TBL[nb];
         e_dp = ~(m_adp[idx] & show);
         e_an = (dv != 0 && pw <= brightness && !blank_in && show) ? ~(4'b1 << idx) : 4'hF;
         e_ft = (t % 16 == 15);
      end
      @(posedge clk);
      if (!rst_n) begin
         t = 0; m_act = 0; m_pbuf = 0; m_adp = 0; m_pdp = 0; m_pend = 0;
      end else begin
         if (t % 16 == 15 && m_pend) begin m_act = m_pbuf; m_adp = m_pdp; m_pend = 0; end
         if (load) begin m_pbuf = value; m_pdp = dp_in; m_pend = 1; end
         t++;
      end
      #1;
      chk("seg", seg, e_seg);
      chk("dp", dp, e_dp);
      chk("an", an, e_an);
      chk("frame_tick", frame_tick, e_ft);
      chk("pending", pending, m_pend);
   endtask

   task automatic pulse_load(input logic [15:0] v);
      value = v; load = 1; step(); load = 0;
   endtask

   task automatic wait_ft();
      int n = 0;
      do begin step(); n++; end while (!frame_tick && n < 40);
      if (!frame_tick) chk("frame_tick_timeout", 0, 1);
   endtask

   initial begin
      logic [3:0] low;
      int cnt, fts;
      vec = '{'{16'h0, 7'h40}, '{16'h1, 7'h79}, '{16'h2, 7'h24}, '{16'h3, 7'h30},
              '{16'h4, 7'h19}, '{16'h5, 7'h12}, '{16'h6, 7'h02}, '{16'h7, 7'h78},
              '{16'h8, 7'h00}, '{16'h9, 7'h10}, '{16'hA, 7'h08}, '{16'hB, 7'h03},
              '{16'hC, 7'h46}, '{16'hD, 7'h21}, '{16'hE, 7'h06}, '{16'hF, 7'h0E}};
      repeat (3) step();
      chk("rst_an", an, 4'hF); chk("rst_seg", seg, 7'h7F); chk("rst_dp", dp, 1);
      chk("rst_pending", pending, 0); chk("rst_ft", frame_tick, 0);
      rst_n = 1;
      repeat (5) step();
      pulse_load(16'h1234);
      chk("pend_set", pending, 1);
      wait_ft();
      chk("pend_clr", pending, 0);
      step(); step();
      chk("d0_an", an, 4'b1110); chk("d0_seg_1234", seg, 7'h19);
      for (int i = 0; i < 16; i++) begin
         pulse_load(vec[i].v);
         wait_ft(); step(); step();
         chk("tbl_an", an, 4'b1110);
         chk($sformatf("tbl_seg_%0d", i), seg, vec[i].s);
      end
      pulse_load(16'hAAAA);
      pulse_load(16'hBBBB);
      wait_ft(); step(); step();
      chk("last_load_seg", seg, 7'h03);
      brightness = 0; cnt = 0;
      repeat (64) begin step(); if (an != 4'hF) cnt++; end
      chk("br0_an_active", cnt, 0);
      brightness = 15; blank_in = 1; cnt = 0; fts = 0;
      repeat (64) begin step(); if (an != 4'hF) cnt++; if (frame_tick) fts++; end
      chk("blank_an_active", cnt, 0); chk("blank_ft_count", fts, 4);
      blank_in = 0;
      pulse_load(16'h0050);
      wait_ft(); low = 0;
      repeat (16) begin
         step(); low |= ~an;
         if (an == 4'b1110) chk("lzb_d0_seg", seg, 7'h40);
      end
`ifdef SEG_LZB_EN
      chk("lzb_mask", low, 4'b0011);
`else
      chk("lzb_mask", low, 4'b1111);
`endif
      pulse_load(16'hFFFF);
      repeat (3) step();
      rst_n = 0; step();
      chk("rst_mid_pending", pending, 0);
      rst_n = 1;
      wait_ft(); step(); step();
      chk("rst_discard_seg", seg, 7'h40);
      repeat (3000) begin
         load = ($urandom % 6) == 0;
         value = 16'($urandom);
         dp_in = 4'($urandom);
         if ($urandom % 50 == 0) brightness = 4'($urandom);
         if ($urandom % 40 == 0) blank_in = ~blank_in;
         rst_n = ($urandom % 400) != 0;
         if ($urandom % 3 == 0) value[15:8] = 0;
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
